vga_text_loader: RTL and testbench
==================================

// Module: vga_text_loader
// PURPOSE
//  Frame-synchronous loader for the VGA text console. Fetches the 256-byte coded
//  text and the 256-byte decoded text from shared data memory through a req/gnt
//  read port into shadow buffers. Commits both to the VGA character arrays only
//  at the start of vertical sync, so a frame never shows half-updated text.
//  Sits between the CPU memory arbiter and the VGA top (drives char_data_coded
//  and char_data).
// PARAMETERS
//  ADDR_W      16      width of mem_addr (byte address)
//  CODED_BASE  16'h0400 first byte address of the coded text region (256 bytes)
//  PLAIN_BASE  16'h0500 first byte address of the decoded text region (256 bytes)
//  BLANK_CHAR  8'h20   reset/fill value of every output character (ASCII space)
// PORTS
//  clk              in   1        system clock, all logic on rising edge
//  reset            in   1        asynchronous, active-low reset
//  start            in   1        1-cycle pulse from CPU: reload both text regions
//  vsync            in   1        VGA vsync (active-low pulse); commit point = its falling edge
//  mem_req          out  1        read request to memory arbiter
//  mem_addr         out  ADDR_W   byte address of current request
//  mem_gnt          in   1        arbiter accepts request this cycle (req & gnt = handshake)
//  mem_rdata        in   8        read data, valid exactly 1 cycle after handshake
//  char_data_coded  out  8x256    committed coded text, index 0..255
//  char_data        out  8x256    committed decoded text, index 0..255
//  busy             out  1        1 from accepted start until commit completes
//  done             out  1        1-cycle pulse in the cycle after commit
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, index=0, mem_req=0, mem_addr=0, busy=0,
//   done=0, shadow and output arrays all BLANK_CHAR, vsync edge register=1.
//  Index: 9-bit counter idx. idx[8]=0 selects coded region, idx[8]=1 selects
//   plain region. mem_addr = (idx[8] ? PLAIN_BASE : CODED_BASE) + idx[7:0].
//  FSM:
//   IDLE   : busy=0. start=1 -> idx=0, busy=1, go REQ. Otherwise stay.
//   REQ    : mem_req=1, mem_addr held stable. mem_gnt=0 -> stay (req/addr held).
//            mem_gnt=1 -> go DATA.
//   DATA   : mem_req=0. Write mem_rdata to shadow[idx]. idx==511 -> go WAIT_VS,
//            else idx+1 and go REQ.
//   WAIT_VS: mem_req=0. Wait for a vsync falling edge (vsync_q=1 & vsync=0) -> go COMMIT.
//   COMMIT : one cycle. Copy shadow coded/plain -> char_data_coded/char_data in full,
//            done=1 next cycle, busy=0 next cycle, go IDLE.
//  Throughput: 2 cycles per byte with gnt held high. Min start->commit is 1024
//   cycles plus the vsync wait.
//  Outputs change only in COMMIT. They are stable during all other states,
//   including during loading.
//  A vsync falling edge seen while in REQ/DATA is ignored. The commit waits for
//   the next edge after all 512 bytes.
//  A vsync falling edge in the same cycle WAIT_VS is entered is not counted. The
//   edge must occur while in WAIT_VS.
//  start while busy=1 (any non-IDLE state) is ignored and no reload is queued.
//  start in the same cycle as done=1 (state IDLE) is accepted.
//  Reset mid-operation clears everything to the reset values above. The load is
//   abandoned and the outputs return to BLANK_CHAR.
//  mem_rdata is sampled only in DATA. Values on other cycles are don't-care.
// TESTING
//  1 reset=0 then 1 -> all 512 output chars=8'h20, busy=0, mem_req=0, done=0.
//  2 gnt tied 1, memory returns addr[7:0]^8'hA5, start pulse, vsync fall at
//    cycle 1500 -> mem_addr sequence 0x0400..0x04FF,0x0500..0x05FF.
//    char_data_coded[i]=i^A5, char_data[i]=i^A5; done pulses once; outputs
//    unchanged before commit.
//  3 gnt random 30% duty -> mem_req/mem_addr held stable while gnt=0; final arrays
//    identical to scenario 2; no address skipped or repeated.
//  4 vsync fall at cycle 200 (mid-load) and again after load -> no commit at 200;
//    commit on the second edge only.
//  5 second start at idx=100 -> ignored; exactly 512 requests, one done pulse.
//  6 reset asserted at idx=300 after a prior completed load -> outputs return to
//    8'h20, busy=0; a new start then completes normally.

Source files
------------

// File: rtl/vga_text_loader.sv
// Frame-synchronous VGA text loader: fetches coded and plain text into shadow
// buffers and commits both to the character arrays on a vsync falling edge.
module vga_text_loader #(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] CODED_BASE = 16'h0400,
    parameter logic [ADDR_W-1:0] PLAIN_BASE = 16'h0500,
    parameter logic [7:0]        BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              vsync,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        char_data_coded [256],
    output logic [7:0]        char_data       [256],
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DATA,
        WAIT_VS,
        COMMIT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [8:0]  idx;
    logic        vsync_q;
    logic        vs_fall;
    logic [7:0]  shadow [512];

    assign vs_fall = vsync_q & ~vsync;

    always_comb begin
        state_n  = state;
        mem_req  = 1'b0;
        mem_addr = '0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) state_n = REQ;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = (idx[8] ? PLAIN_BASE : CODED_BASE)
                         + {{(ADDR_W-8){1'b0}}, idx[7:0]};
                if (mem_gnt) state_n = DATA;
            end
            DATA: begin
                state_n = (idx == 9'd511) ? WAIT_VS : REQ;
            end
            WAIT_VS: begin
                if (vs_fall) state_n = COMMIT;
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            vsync_q <= 1'b1;
            done    <= 1'b0;
            for (int i = 0; i < 512; i++) shadow[i] <= BLANK_CHAR;
            for (int i = 0; i < 256; i++) begin
                char_data_coded[i] <= BLANK_CHAR;
                char_data[i]       <= BLANK_CHAR;
            end
        end else begin
            vsync_q <= vsync;
            done    <= (state == COMMIT);
            if (state == IDLE && start) idx <= '0;
            if (state == DATA) begin
                shadow[idx] <= mem_rdata;
                idx         <= idx + 9'd1;
            end
            // Whole-frame commit keeps the display free of half-loaded text.
            if (state == COMMIT) begin
                for (int i = 0; i < 256; i++) begin
                    char_data_coded[i] <= shadow[i];
                    char_data[i]       <= shadow[256 + i];
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_text_loader.sv
// Directed bench for vga_text_loader: memory model, handshake monitor and
// linear scenario sequence with immediate assertions.
module tb_vga_text_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        vsync;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  char_data_coded [256];
    logic [7:0]  char_data       [256];
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    int          hs_count = 0;
    int          load_idx = 0;
    int          addr_err = 0;
    int          hold_err = 0;
    int          done_cnt = 0;
    logic [7:0]  key = 8'hA5;
    bit          rand_gnt = 1'b0;
    logic [7:0]  nxt_rdata = 8'h00;
    bit          pend = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    logic [15:0] exp_addr;

    int base_hs;
    int base_done;
    bit ok;

    vga_text_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .vsync           (vsync),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_gnt         (mem_gnt),
        .mem_rdata       (mem_rdata),
        .char_data_coded (char_data_coded),
        .char_data       (char_data),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Monitor: handshakes, address order, request hold, done pulses.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (!reset) begin
            load_idx = 0;
            pend     = 1'b0;
        end else begin
            if (pend && !(mem_req === 1'b1 && mem_addr === pend_addr))
                hold_err++;
            pend      = (mem_req === 1'b1) && (mem_gnt === 1'b0);
            pend_addr = mem_addr;
            if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
                exp_addr = (load_idx < 256)
                         ? 16'(16'h0400 + load_idx)
                         : 16'(16'h0500 + load_idx - 256);
                if (mem_addr !== exp_addr) addr_err++;
                hs_count++;
                load_idx  = (load_idx + 1) % 512;
                nxt_rdata = mem_addr[7:0] ^ key;
            end else begin
                nxt_rdata = 8'($urandom);
            end
        end
    end

    // Memory: data one cycle after handshake, grant updated after each edge.
    always @(posedge clk) begin
        #1 mem_rdata = nxt_rdata;
        #1 mem_gnt = rand_gnt ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bad_cnt(input logic [7:0] k, input bit blank);
        int n;
        logic [7:0] e;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            e = blank ? 8'h20 : (8'(i) ^ k);
            if (char_data_coded[i] !== e) n++;
            if (char_data[i] !== e) n++;
        end
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic wait_done(input int n, output bit found);
        for (int i = 0; i < n; i++) begin
            if (done_cnt != base_done) break;
            @(negedge clk);
        end
        found = (done_cnt != base_done);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst arrays blank", bad_cnt(8'h00, 1'b1), 0);
        chk("rst busy", busy, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst done", done, 0);
        chk("rst mem_addr", mem_addr, 0);

        // Full load with grant held high
        key = 8'hA5;
        base_hs = hs_count;
        base_done = done_cnt;
        pulse_start();
        repeat (1100) @(negedge clk);
        chk("s2 busy in wait", busy, 1);
        chk("s2 no req in wait", mem_req, 0);
        chk("s2 pre-commit blank", bad_cnt(8'h00, 1'b1), 0);
        chk("s2 no early done", done_cnt - base_done, 0);
        repeat (398) @(negedge clk);
        pulse_vsync();
        wait_done(50, ok);
        chk("s2 done seen", ok, 1);
        @(negedge clk);
        chk("s2 busy cleared", busy, 0);
        chk("s2 handshakes", hs_count - base_hs, 512);
        chk("s2 done count", done_cnt - base_done, 1);
        chk("s2 addr order", addr_err, 0);
        chk("s2 arrays", bad_cnt(8'hA5, 1'b0), 0);
        chk("s2 coded[0]", char_data_coded[0], 8'hA5);
        chk("s2 plain[255]", char_data[255], 8'h5A);

        // Vsync edge during loading must not commit
        key = 8'h3C;
        base_hs = hs_count;
        base_done = done_cnt;
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_vsync();
        repeat (20) @(negedge clk);
        chk("s4 busy mid-load", busy, 1);
        chk("s4 no mid-load done", done_cnt - base_done, 0);
        chk("s4 outputs held", bad_cnt(8'hA5, 1'b0), 0);
        repeat (1000) @(negedge clk);
        chk("s4 no done before edge", done_cnt - base_done, 0);
        pulse_vsync();
        wait_done(50, ok);
        chk("s4 done seen", ok, 1);
        chk("s4 arrays", bad_cnt(8'h3C, 1'b0), 0);
        chk("s4 handshakes", hs_count - base_hs, 512);

        // Random grant
        rand_gnt = 1'b1;
        key = 8'hA5;
        base_hs = hs_count;
        base_done = done_cnt;
        pulse_start();
        for (int i = 0; i < 8000; i++) begin
            if (hs_count - base_hs >= 512) break;
            @(negedge clk);
        end
        chk("s3 load complete", hs_count - base_hs, 512);
        repeat (5) @(negedge clk);
        chk("s3 req idle in wait", mem_req, 0);
        chk("s3 no early done", done_cnt - base_done, 0);
        pulse_vsync();
        wait_done(50, ok);
        chk("s3 done seen", ok, 1);
        chk("s3 hold stable", hold_err, 0);
        chk("s3 addr order", addr_err, 0);
        chk("s3 arrays", bad_cnt(8'hA5, 1'b0), 0);
        rand_gnt = 1'b0;

        // Second start during load is ignored
        key = 8'h5A;
        repeat (3) @(negedge clk);
        base_hs = hs_count;
        base_done = done_cnt;
        pulse_start();
        repeat (200) @(negedge clk);
        chk("s5 busy", busy, 1);
        pulse_start();
        repeat (1000) @(negedge clk);
        pulse_vsync();
        wait_done(50, ok);
        chk("s5 done seen", ok, 1);
        chk("s5 handshakes", hs_count - base_hs, 512);
        chk("s5 arrays", bad_cnt(8'h5A, 1'b0), 0);
        repeat (1100) @(negedge clk);
        pulse_vsync();
        repeat (10) @(negedge clk);
        chk("s5 idle busy", busy, 0);
        chk("s5 idle req", mem_req, 0);
        chk("s5 no extra reqs", hs_count - base_hs, 512);
        chk("s5 one done", done_cnt - base_done, 1);

        // Reset mid-load, then a clean reload
        key = 8'hC3;
        pulse_start();
        repeat (600) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("s6 reset blank", bad_cnt(8'h00, 1'b1), 0);
        chk("s6 reset busy", busy, 0);
        chk("s6 reset req", mem_req, 0);
        chk("s6 reset done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        key = 8'h0F;
        base_hs = hs_count;
        base_done = done_cnt;
        pulse_start();
        repeat (1100) @(negedge clk);
        pulse_vsync();
        wait_done(50, ok);
        chk("s6 done seen", ok, 1);
        chk("s6 handshakes", hs_count - base_hs, 512);
        chk("s6 addr order", addr_err, 0);
        chk("s6 arrays", bad_cnt(8'h0F, 1'b0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
